// File: rtl/mem_copy_dma.sv
// Word-granular block-copy initiator on the native mem_valid/mem_ready bus.
// Reads each source word, writes it to the destination, then pulses done.
module mem_copy_dma #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdGap,
    StWrReq,
    StWrGap,
    StFin
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      tmo_q, tmo_d;
  logic             tmo_hit;

  // tmo_q counts completed waiting cycles; this cycle would be number tmo_q+1.
  assign tmo_hit = (TIMEOUT != 0) && ((tmo_q + 32'd1) >= TIMEOUT);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_addr & 32'hFFFF_FFFC;
          dst_d   = dst_addr & 32'hFFFF_FFFC;
          rem_d   = len_words;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (len_words == '0) ? StFin : StRdReq;
        end
      end

      StRdReq: begin
        if (!valid_q) begin
          // First read after start: present the request one cycle after acceptance.
          valid_d = 1'b1;
          addr_d  = src_q;
          wstrb_d = 4'h0;
          tmo_d   = '0;
        end else if (mem_ready) begin
          data_d  = mem_rdata;
          valid_d = 1'b0;
          src_d   = src_q + 32'd4;
          state_d = StRdGap;
        end else if (tmo_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      StRdGap: begin
        valid_d = 1'b1;
        addr_d  = dst_q;
        wstrb_d = 4'hF;
        tmo_d   = '0;
        state_d = StWrReq;
      end

      StWrReq: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - LEN_W'(1);
          state_d = StWrGap;
        end else if (tmo_hit) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      StWrGap: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end else begin
          valid_d = 1'b1;
          addr_d  = src_q;
          wstrb_d = 4'h0;
          tmo_d   = '0;
          state_d = StRdReq;
        end
      end

      StFin: begin
        // Entered with done already set except on the zero-length path.
        if (done_q) begin
          state_d = StIdle;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_valid = valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Scoreboard bench for mem_copy_dma: expected bus beats and done/err results are queued
// at issue time and popped by a monitor as the DUT presents them.
module tb_mem_copy_dma;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  mem_copy_dma #(
    .TIMEOUT(16),
    .LEN_W  (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len_words(len_words),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder: 4K-word RAM, ready after resp_lat cycles of valid; resp_lat 0 = never ready.
  logic [31:0] mem [4096];
  int          resp_lat;
  int          wcnt;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem[a[13:2]];
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      wcnt      <= 0;
    end else if (mem_valid && !mem_ready && resp_lat != 0) begin
      if (wcnt + 1 >= resp_lat) begin
        mem_ready <= 1'b1;
        wcnt      <= 0;
        if (mem_wstrb == 4'hF) mem[mem_addr[13:2]] <= mem_wdata;
        else mem_rdata <= mem[mem_addr[13:2]];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t beat_q[$];
  beat_t exp_mem[$];
  bit    done_q[$];

  // Monitor: pop a beat on every handshake, a done result on every done cycle.
  logic        prev_valid;
  logic [67:0] held;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_valid && prev_valid)
        check("bus_stable", {31'd0, held != {mem_addr, mem_wstrb, mem_wdata}}, 32'd0);
      if (mem_valid && mem_ready) begin
        check("mem_instr", {31'd0, mem_instr}, 32'd0);
        if (beat_q.size() == 0) begin
          check("unexpected_beat", mem_addr, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check(b.wr ? "wr_addr" : "rd_addr", mem_addr, b.addr);
          check("wstrb", {28'd0, mem_wstrb}, b.wr ? 32'hF : 32'h0);
          if (b.wr) check("wr_data", mem_wdata, b.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          bit e;
          e = done_q.pop_front();
          check("err_at_done", {31'd0, err}, {31'd0, e});
          check("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      prev_valid = mem_valid;
      held       = {mem_addr, mem_wstrb, mem_wdata};
    end
  end

  // Reference model: word-by-word copy from aligned src to aligned dst.
  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                           input bit e);
    logic [31:0] sa, da;
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      logic [31:0] ra, wa, w;
      ra = sa + 32'(4 * i);
      wa = da + 32'(4 * i);
      w  = mem_rd(ra);
      beat_q.push_back('{wr: 1'b0, addr: ra, data: w});
      beat_q.push_back('{wr: 1'b1, addr: wa, data: w});
      exp_mem.push_back('{wr: 1'b1, addr: wa, data: w});
    end
    done_q.push_back(e);
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    src_addr  = s;
    dst_addr  = d;
    len_words = 16'(n);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cyc = negedges after the start edge up to and including the first with done high.
  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < max);
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_copy();
    #1;
    check("beats_left", beat_q.size(), 32'd0);
    check("dones_left", done_q.size(), 32'd0);
    while (exp_mem.size() > 0) begin
      beat_t b;
      b = exp_mem.pop_front();
      check("dst_contents", mem_rd(b.addr), b.data);
    end
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
  endtask

  task automatic copy(input logic [31:0] s, input logic [31:0] d, input int n, output int cyc);
    push_copy(s, d, n, 1'b0);
    pulse_start(s, d, n);
    wait_done(40 * n + 20, cyc);
    finish_copy();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int cyc, vcnt, bcnt, dcnt, first_done, wr_rises;
    bit pv;

    resetn    = 1'b0;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    len_words = '0;
    resp_lat  = 1;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_instr", {31'd0, mem_instr}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Four words RAM to RAM, single-cycle responder: 6 cycles per word.
    copy(32'h100, 32'h200, 4, cyc);
    check("latency_4w_in_window", {31'd0, (cyc - 1 >= 23) && (cyc - 1 <= 25)}, 32'd1);

    // Unaligned addresses are truncated to word boundaries.
    copy(32'h103, 32'h0300_0002, 1, cyc);
    check("led_nibble", {28'd0, mem_rd(32'h0300_0000) & 32'hF}, {28'd0, mem_rd(32'h100) & 32'hF});

    // Zero length: no bus traffic, one done, busy at most one cycle.
    done_q.push_back(1'b0);
    pulse_start(32'h100, 32'h200, 0);
    vcnt = 0; bcnt = 0; dcnt = 0; first_done = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (mem_valid) vcnt++;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (first_done == 0) first_done = i;
      end
    end
    check("len0_valid_cycles", vcnt, 32'd0);
    check("len0_done_pulses", dcnt, 32'd1);
    check("len0_busy_le1", {31'd0, bcnt <= 1}, 32'd1);
    check("len0_done_prompt", {31'd0, first_done >= 1 && first_done <= 3}, 32'd1);

    // Responder never ready: abort after 16 valid cycles with err set.
    resp_lat = 0;
    done_q.push_back(1'b1);
    pulse_start(32'h400, 32'h800, 3);
    vcnt = 0;
    cyc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_valid) vcnt++;
    end while (!done && cyc < 200);
    check("tmo_done_seen", {31'd0, done}, 32'd1);
    check("tmo_valid_cycles", vcnt, 32'd16);
    @(negedge clk);
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
    check("tmo_valid_low", {31'd0, mem_valid}, 32'd0);
    check("tmo_dones_left", done_q.size(), 32'd0);
    resp_lat = 1;
    push_copy(32'h500, 32'h900, 2, 1'b0);
    pulse_start(32'h500, 32'h900, 2);
    @(negedge clk);
    check("err_cleared_on_start", {31'd0, err}, 32'd0);
    wait_done(100, cyc);
    finish_copy();

    // Source address wraps modulo 2^32.
    copy(32'hFFFF_FFFC, 32'h2000, 2, cyc);

    // Random copies with variable latency and a spurious start while busy.
    for (int it = 0; it < 8; it++) begin
      logic [31:0] s, d;
      int          n;
      resp_lat = $urandom_range(1, 3);
      s = 32'h1000 + 32'($urandom_range(0, 'h7E0));
      d = 32'h1800 + 32'($urandom_range(0, 'h7E0));
      n = $urandom_range(1, 8);
      push_copy(s, d, n, 1'b0);
      pulse_start(s, d, n);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_start(32'h0000_3000, 32'h0000_3800, 5);
      wait_done(40 * n + 20, cyc);
      finish_copy();
    end
    resp_lat = 1;

    // Reset during the second word's write request, then a clean copy.
    push_copy(32'h300, 32'h600, 3, 1'b0);
    pulse_start(32'h300, 32'h600, 3);
    wr_rises = 0;
    pv       = 1'b0;
    for (int i = 0; i < 100 && wr_rises < 2; i++) begin
      @(negedge clk);
      if (mem_valid && mem_wstrb == 4'hF && !pv) wr_rises++;
      pv = mem_valid && mem_wstrb == 4'hF;
    end
    check("reached_word2_write", wr_rises, 32'd2);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    beat_q.delete();
    done_q.delete();
    exp_mem.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_done", {31'd0, done}, 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_done", {31'd0, done}, 32'd0);
    copy(32'h300, 32'h600, 3, cyc);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Word-granular block-copy engine acting as an initiator on the SoC's native memory bus (mem_valid / mem_ready handshake, same signalling the RAM, UART and GPIO responders implement). Given a source address, destination address and word count, it reads each word from the source responder and writes it to the destination responder, then signals completion. It sits beside the CPU as a second bus initiator, behind the SoC arbiter, and lets firmware or a debug loader move buffers (e.g. RAM → GPIO/UART or RAM → RAM) without CPU load/store loops.

## Interface
- TIMEOUT, 1024: cycles mem_valid may stay high without mem_ready before the engine aborts; 0 disables the timeout.
- LEN_W, 16: width of the word-count input.

- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- start  in  1  one-cycle request, sampled only in IDLE.
- src_addr  in  32  source byte address; bits [1:0] ignored (treated as 0).
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- len_words  in  LEN_W  number of 32-bit words to copy.
- busy  out  1  high from the cycle after accepted start until the done cycle.
- done  out  1  one-cycle pulse at end of every accepted start (success or abort).
- err  out  1  sticky timeout flag; cleared on next accepted start.
- mem_valid  out  1  bus request.
- mem_instr  out  1  tied 0.
- mem_ready  in  1  responder completion.
- mem_addr  out  32  word-aligned bus address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'hF for writes, 4'h0 for reads.
- mem_rdata  in  32  read data, valid when mem_ready is high.

## Operation
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FIN.
- IDLE: on start=1 latch src/dst (low bits zeroed), len into remaining counter, clear err. len=0 → FIN directly; else → RD_REQ.
- RD_REQ: mem_valid=1, mem_addr=src, mem_wstrb=0. When mem_ready=1 sampled: capture mem_rdata into data register, mem_valid<=0, src+=4 → RD_GAP.
- RD_GAP (1 cycle, valid low) → WR_REQ.
- WR_REQ: mem_valid=1, mem_addr=dst, mem_wdata=data reg, mem_wstrb=4'hF. On mem_ready: mem_valid<=0, dst+=4, remaining-=1 → WR_GAP.
- WR_GAP: remaining=0 → FIN; else → RD_REQ.
- FIN: done=1 for one cycle, busy<=0 → IDLE.
- Address increment is modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000); no error.
- mem_addr/mem_wstrb/mem_wdata held stable for the whole time mem_valid is high.
- Timeout: counter resets on each mem_valid rise, increments each REQ cycle without mem_ready; reaching TIMEOUT → mem_valid<=0, err<=1, → FIN (done pulses). Remaining words not transferred.
- start while busy: ignored, no effect on latched parameters.
- mem_ready while mem_valid low: ignored.

## Timing
- Reset values: mem_valid 0, mem_instr 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, busy 0, done 0, err 0; state IDLE. Assertion of resetn mid-transfer drops mem_valid immediately (asynchronously); no done pulse.
- start sampled at edge E0 → mem_valid high after E1 (RD_REQ registered outputs).
- Responder with one-cycle ready (all current responders): each beat = 2 cycles valid high + 1 gap cycle; 6 cycles per word.
- mem_valid falls on the edge at which mem_ready=1 is sampled, so a responder's guard (valid && !ready) never sees a duplicate request.
- done asserted the cycle after the final WR_GAP; busy falls together with done.
- len=0: done 2 cycles after start edge, zero bus beats.

## Test plan
- Copy 4 words RAM 0x100 → RAM 0x200, 1-cycle responder: 8 beats, addresses 0x100,0x200,0x104,0x204…, 0x20C contents match, done 24±1 cycles after start, err=0.
- Unaligned inputs src=0x103, dst=0x03000002, len=1: read at 0x100, write at 0x03000000 with wstrb=F; LED register equals low nibble of word.
- len=0: no mem_valid ever high, single done pulse, busy high ≤1 cycle.
- Responder never asserts ready, TIMEOUT=16: mem_valid drops after 16 cycles, err=1, done pulses; next start with good responder clears err.
- Wrap: src=0xFFFFFFFC, len=2: second read at 0x00000000.
- Assert resetn=0 during WR_REQ of word 2: mem_valid 0 in the same cycle, busy 0, no done; start after release copies normally; start pulsed while busy is ignored.
